// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def: shared encodings for the data-memory controller.
//   dmtype_e  - load/store access type carried on dmtype[2:0]
//   dstate_e  - dmem_ctrl FSM state codes
//   Helpers   - misalignment test, store byte mask, load lane extraction
// ---------------------------------------------------------------------------
package ctrl_encode_def;

   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dmtype_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RD_WAIT = 2'b01,
      ST_RD_DONE = 2'b10,
      ST_FLUSH   = 2'b11
   } dstate_e;

   // Unused dmtype codes are handled as word accesses.
   function automatic logic is_misaligned(input logic [2:0] dt, input logic [1:0] off);
      case (dmtype_e'(dt))
         DM_HALF, DM_HALF_U: return off[0];
         DM_BYTE, DM_BYTE_U: return 1'b0;
         default:            return (off != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] dt, input logic [1:0] off);
      case (dmtype_e'(dt))
         DM_HALF, DM_HALF_U: return off[1] ? 4'b1100 : 4'b0011;
         DM_BYTE, DM_BYTE_U: return 4'b0001 << off;
         default:            return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] dt, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = 16'(word >> {off[1], 4'b0000});
      case (dmtype_e'(dt))
         DM_HALF:   return {{16{h[15]}}, h};
         DM_HALF_U: return {16'h0000, h};
         DM_BYTE:   return {{24{b[7]}}, b};
         DM_BYTE_U: return {24'h000000, b};
         default:   return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ctrl_sb.sv
// ---------------------------------------------------------------------------
// sb_fifo: store buffer, FIFO of {word address, byte mask, lane data}.
//   clk, rst (sync, active-low)
//   push/push_addr/push_mask/push_data : enqueue (ignored when full)
//   pop                                 : dequeue head (ignored when empty)
//   head_addr/head_mask/head_data       : oldest entry
//   full, empty, count                  : occupancy (count is ptr width + 1)
//   match_addr -> match_vec             : per-entry valid address hit
// ---------------------------------------------------------------------------
module sb_fifo #(
   parameter int SB_DEPTH = 4,
   parameter int AW       = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [AW-1:0]               push_addr,
   input  logic [3:0]                  push_mask,
   input  logic [31:0]                 push_data,
   input  logic                        pop,
   output logic [AW-1:0]               head_addr,
   output logic [3:0]                  head_mask,
   output logic [31:0]                 head_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(SB_DEPTH):0]   count,
   input  logic [AW-1:0]               match_addr,
   output logic [SB_DEPTH-1:0]         match_vec
);

   localparam int PW = $clog2(SB_DEPTH);

   logic [AW-1:0]       addr_mem [SB_DEPTH];
   logic [3:0]          mask_mem [SB_DEPTH];
   logic [31:0]         data_mem [SB_DEPTH];
   logic [SB_DEPTH-1:0] valid;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                push_ok;
   logic                pop_ok;

   assign full    = (count == (PW+1)'(SB_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign head_addr = addr_mem[rd_ptr];
   assign head_mask = mask_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (push_ok) begin
            addr_mem[wr_ptr] <= push_addr;
            mask_mem[wr_ptr] <= push_mask;
            data_mem[wr_ptr] <= push_data;
            valid[wr_ptr]    <= 1'b1;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      match_vec = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         match_vec[i] = valid[i] && (addr_mem[i] == match_addr);
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl: MEM-stage data memory controller with a store buffer.
//   clk, rst (sync, active-low)
//   mem_r, mem_w, addr, wdata, dmtype : request from MEM stage
//   rdata    : extended load data (non-zero only in RD_DONE)
//   stall    : hold IF..MEM
//   misalign : current request misaligned (access suppressed)
//   sram_en, sram_we, sram_addr, sram_wdata, sram_rdata : single-port SRAM
// Stores go to the buffer; the buffer drains to SRAM whenever the port is
// not needed for a load read. A load that hits a buffered word flushes first.
// ---------------------------------------------------------------------------
module dmem_ctrl
   import ctrl_encode_def::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int SB_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mem_r,
   input  logic                           mem_w,
   input  logic [31:0]                    addr,
   input  logic [31:0]                    wdata,
   input  logic [2:0]                     dmtype,
   output logic [31:0]                    rdata,
   output logic                           stall,
   output logic                           misalign,
   output logic                           sram_en,
   output logic [3:0]                     sram_we,
   output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr,
   output logic [31:0]                    sram_wdata,
   input  logic [31:0]                    sram_rdata
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(SB_DEPTH) + 1;

   dstate_e             state;
   dstate_e             state_nxt;
   logic [31:0]         rd_q;
   logic [AW-1:0]       word_addr;
   logic                req_bad;
   logic                ld_req;
   logic                st_req;
   logic                do_read;
   logic                sb_push;
   logic                sb_pop;
   logic                sb_full;
   logic                sb_empty;
   logic                sb_hit;
   logic [CW-1:0]       sb_count;
   logic [AW-1:0]       sb_head_addr;
   logic [3:0]          sb_head_mask;
   logic [31:0]         sb_head_data;
   logic [SB_DEPTH-1:0] sb_match;
   logic                unused_addr_hi;

   // High address bits are dropped so accesses wrap inside the SRAM.
   assign word_addr      = addr[AW+1:2];
   assign unused_addr_hi = ^addr[31:AW+2];

   // Simultaneous mem_r/mem_w is a load.
   assign req_bad = (mem_r || mem_w) && is_misaligned(dmtype, addr[1:0]);
   assign ld_req  = mem_r && !req_bad;
   assign st_req  = mem_w && !mem_r && !req_bad;
   assign sb_hit  = |sb_match;

   sb_fifo #(
      .SB_DEPTH (SB_DEPTH),
      .AW       (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .push       (sb_push),
      .push_addr  (word_addr),
      .push_mask  (store_mask(dmtype, addr[1:0])),
      .push_data  (wdata << {addr[1:0], 3'b000}),
      .pop        (sb_pop),
      .head_addr  (sb_head_addr),
      .head_mask  (sb_head_mask),
      .head_data  (sb_head_data),
      .full       (sb_full),
      .empty      (sb_empty),
      .count      (sb_count),
      .match_addr (word_addr),
      .match_vec  (sb_match)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pipeline holds the request stable, so dmtype/addr still describe the
   // load while the SRAM word arrives in RD_WAIT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q <= '0;
      end else if (state == ST_RD_WAIT) begin
         rd_q <= load_extend(dmtype, addr[1:0], sram_rdata);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (ld_req) state_nxt = sb_hit ? ST_FLUSH : ST_RD_WAIT;
         ST_RD_WAIT: state_nxt = ST_RD_DONE;
         ST_RD_DONE: state_nxt = ST_IDLE;
         // FLUSH pops every cycle, so a single remaining entry leaves it empty.
         ST_FLUSH:   if (sb_empty || sb_count == CW'(1)) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Pushes take priority over drains while stores stream in; the head only
   // drains alongside a store when the buffer is full and the store waits.
   always_comb begin
      stall      = 1'b0;
      do_read    = 1'b0;
      sb_push    = 1'b0;
      sb_pop     = 1'b0;
      sram_en    = 1'b0;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (rst) begin
         case (state)
            ST_IDLE: begin
               if (ld_req) begin
                  stall = 1'b1;
                  if (sb_hit) sb_pop  = 1'b1;
                  else        do_read = 1'b1;
               end else if (st_req) begin
                  if (sb_full) begin
                     stall  = 1'b1;
                     sb_pop = 1'b1;
                  end else begin
                     sb_push = 1'b1;
                  end
               end else begin
                  sb_pop = !sb_empty;
               end
            end
            ST_RD_WAIT: begin
               stall  = 1'b1;
               sb_pop = !sb_empty;
            end
            ST_RD_DONE: sb_pop = !sb_empty;
            ST_FLUSH: begin
               stall  = 1'b1;
               sb_pop = !sb_empty;
            end
            default: ;
         endcase
         if (do_read) begin
            sram_en   = 1'b1;
            sram_addr = word_addr;
         end else if (sb_pop) begin
            sram_en    = 1'b1;
            sram_we    = sb_head_mask;
            sram_addr  = sb_head_addr;
            sram_wdata = sb_head_data;
         end
      end
   end

   assign rdata    = (rst && state == ST_RD_DONE) ? rd_q : '0;
   assign misalign = rst && req_bad;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
   import ctrl_encode_def::*;

   logic        clk;
   logic        rst;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  dmtype;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   logic [31:0] mem [1024];
   int          wr_cnt;
   int          flush_cycles;
   int          peak_cnt;
   int          n_tests;
   int          n_fail;

   dmem_ctrl #(
      .DEPTH_WORDS (1024),
      .SB_DEPTH    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r      (mem_r),
      .mem_w      (mem_w),
      .addr       (addr),
      .wdata      (wdata),
      .dmtype     (dmtype),
      .rdata      (rdata),
      .stall      (stall),
      .misalign   (misalign),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: registered read, byte-enabled write.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we == 4'b0000) begin
            sram_rdata <= mem[sram_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
            wr_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (dut.state == ST_FLUSH) flush_cycles++;
      if (int'(dut.u_sb.count) > peak_cnt) peak_cnt = int'(dut.u_sb.count);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_r  = 1'b0;
      mem_w  = 1'b0;
      addr   = '0;
      wdata  = '0;
      dmtype = 3'b000;
   endtask

   // Called at the negedge of the first request cycle; counts stalled cycles.
   task automatic wait_stall_low(output int n);
      n = 0;
      while (stall === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] dt, input int exp_stalls,
                          input logic [31:0] exp_data, input string tag);
      int n;
      mem_r = 1'b1; mem_w = 1'b0; addr = a; dmtype = dt;
      @(negedge clk);
      wait_stall_low(n);
      check_eq({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
      check_eq({tag, "_rdata"}, rdata, exp_data);
      next_cycle();
      mem_r = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] dt, input logic [31:0] d,
                           input int exp_stalls, input string tag);
      int n;
      mem_w = 1'b1; mem_r = 1'b0; addr = a; dmtype = dt; wdata = d;
      @(negedge clk);
      wait_stall_low(n);
      check_eq({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
      next_cycle();
      mem_w = 1'b0;
   endtask

   initial begin
      int          w0;
      int          n;
      logic [31:0] sd [5];

      n_tests = 0; n_fail = 0; wr_cnt = 0; flush_cycles = 0; peak_cnt = 0;
      sram_rdata = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[16] = 32'h8000_1234;

      // Reset with a misaligned load+store request present: all outputs held low.
      rst = 1'b0; mem_r = 1'b1; mem_w = 1'b1; addr = 32'h42; wdata = 32'hFFFF_FFFF; dmtype = 3'b000;
      next_cycle();
      @(negedge clk);
      check_eq("rst_stall",    32'(stall),      32'd0);
      check_eq("rst_rdata",    rdata,           32'd0);
      check_eq("rst_misalign", 32'(misalign),   32'd0);
      check_eq("rst_sram_en",  32'(sram_en),    32'd0);
      check_eq("rst_sram_we",  32'(sram_we),    32'd0);
      check_eq("rst_sram_addr",32'(sram_addr),  32'd0);
      check_eq("rst_sram_wd",  sram_wdata,      32'd0);
      check_eq("rst_count",    32'(dut.u_sb.count), 32'd0);
      next_cycle();
      rst = 1'b1;
      idle_inputs();

      // Word load, empty buffer: read issued in IDLE, 2 stall cycles.
      mem_r = 1'b1; addr = 32'h40; dmtype = 3'b000;
      @(negedge clk);
      check_eq("ldw_sram_en",   32'(sram_en),   32'd1);
      check_eq("ldw_sram_we",   32'(sram_we),   32'd0);
      check_eq("ldw_sram_addr", 32'(sram_addr), 32'h10);
      check_eq("ldw_idle_rdata", rdata,         32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("ldw_wait_stall", 32'(stall),    32'd1);
      check_eq("ldw_wait_rdata", rdata,         32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("ldw_done_stall", 32'(stall),    32'd0);
      check_eq("ldw_done_rdata", rdata,         32'h8000_1234);
      next_cycle();
      idle_inputs();

      do_load(32'h42, 3'b010, 2, 32'h0000_8000, "ldhu");
      do_load(32'h42, 3'b001, 2, 32'hFFFF_8000, "ldh");
      do_load(32'h43, 3'b100, 2, 32'h0000_0080, "ldbu");
      do_load(32'h40 + 32'h1000, 3'b000, 2, 32'h8000_1234, "ldw_wrap");

      // Misaligned word load: suppressed, no stall, no SRAM access.
      mem_r = 1'b1; addr = 32'h42; dmtype = 3'b000;
      @(negedge clk);
      check_eq("mis_flag",    32'(misalign), 32'd1);
      check_eq("mis_stall",   32'(stall),    32'd0);
      check_eq("mis_rdata",   rdata,         32'd0);
      check_eq("mis_sram_en", 32'(sram_en),  32'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check_eq("mis_after_state", 32'(dut.state), 32'(ST_IDLE));
      next_cycle();

      // Byte store then signed-byte load of the same word: drain, flush, read.
      do_store(32'h13, 3'b011, 32'h0000_00AB, 0, "stb");
      check_eq("stb_count", 32'(dut.u_sb.count), 32'd1);
      w0 = wr_cnt;
      flush_cycles = 0;
      mem_r = 1'b1; addr = 32'h13; dmtype = 3'b011;
      @(negedge clk);
      check_eq("fl_stall",   32'(stall),      32'd1);
      check_eq("fl_sram_we", 32'(sram_we),    32'b1000);
      check_eq("fl_sram_ad", 32'(sram_addr),  32'h4);
      check_eq("fl_sram_wd", sram_wdata,      32'hAB00_0000);
      wait_stall_low(n);
      check_eq("fl_stalls",  32'(n),          32'd4);
      check_eq("fl_rdata",   rdata,           32'hFFFF_FFAB);
      check_eq("fl_flushcy", 32'(flush_cycles), 32'd1);
      check_eq("fl_writes",  32'(wr_cnt - w0),  32'd1);
      check_eq("fl_mem",     mem[4],          32'hAB00_0000);
      next_cycle();
      idle_inputs();

      // Five back-to-back word stores into a 4-deep buffer.
      for (int i = 0; i < 5; i++) sd[i] = 32'h1111_0000 + 32'(i * 32'h101);
      peak_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         do_store(32'h100 + 32'(4 * i), 3'b000, sd[i], (i == 4) ? 1 : 0, $sformatf("stw%0d", i));
      end
      check_eq("stw_count_after", 32'(dut.u_sb.count), 32'd4);
      idle_inputs();
      repeat (6) next_cycle();
      check_eq("stw_peak",    32'(peak_cnt),         32'd4);
      check_eq("stw_drained", 32'(dut.u_sb.count),   32'd0);
      for (int i = 0; i < 5; i++) check_eq($sformatf("stw_mem%0d", i), mem[64 + i], sd[i]);

      // Three buffered stores, a missing load, then reset during RD_WAIT.
      do_store(32'h200, 3'b000, 32'hCAFE_0001, 0, "rs0");
      do_store(32'h204, 3'b000, 32'hCAFE_0002, 0, "rs1");
      do_store(32'h208, 3'b000, 32'hCAFE_0003, 0, "rs2");
      mem_r = 1'b1; addr = 32'h300; dmtype = 3'b000;
      next_cycle();
      @(negedge clk);
      check_eq("rs_state_wait", 32'(dut.state),        32'(ST_RD_WAIT));
      check_eq("rs_count_wait", 32'(dut.u_sb.count),   32'd3);
      check_eq("rs_drain_we",   32'(sram_we),          32'b1111);
      rst = 1'b0;
      #1;
      check_eq("rs_we_in_rst",  32'(sram_we),          32'd0);
      w0 = wr_cnt;
      next_cycle();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      check_eq("rs_state",  32'(dut.state),      32'(ST_IDLE));
      check_eq("rs_count",  32'(dut.u_sb.count), 32'd0);
      check_eq("rs_we",     32'(sram_we),        32'd0);
      check_eq("rs_stall",  32'(stall),          32'd0);
      check_eq("rs_writes", 32'(wr_cnt - w0),    32'd0);
      check_eq("rs_mem",    mem[128],            32'd0);
      next_cycle();

      // Halfword store to upper lane, then unsigned half load back through flush.
      do_store(32'h22, 3'b001, 32'h1234_BEEF, 0, "sth");
      do_load(32'h22, 3'b010, 4, 32'h0000_BEEF, "ldh_fl");
      check_eq("sth_mem", mem[8], 32'hBEEF_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
